mem_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline, between EX and WB. Holds one instruction.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_load_align.sv | 28 ++
 rtl/mem_stage.sv | 90 +++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths and load-op encodings for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int unsigned EsToMsBusWd = 74;
    localparam int unsigned MsToWsBusWd = 70;
    localparam int unsigned MsToDsBusWd = 39;

    // Codes 6 and 7 are not assigned and behave like LoadOpLw.
    typedef enum logic [2:0] {
        LoadOpNone = 3'd0,
        LoadOpLb   = 3'd1,
        LoadOpLbu  = 3'd2,
        LoadOpLh   = 3'd3,
        LoadOpLhu  = 3'd4,
        LoadOpLw   = 3'd5
    } load_op_e;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM/WB handshake, data-SRAM response and ID forwarding signals of the MEM stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                   ms_allowin;
    logic                   es_to_ms_valid;
    logic [EsToMsBusWd-1:0] es_to_ms_bus;
    logic                   ws_allowin;
    logic                   ms_to_ws_valid;
    logic [MsToWsBusWd-1:0] ms_to_ws_bus;
    logic                   data_sram_data_ok;
    logic [31:0]            data_sram_rdata;
    logic [MsToDsBusWd-1:0] ms_to_ds_bus;

    // Surrounding pipeline / SRAM side.
    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

    // MEM stage side.
    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  ofs,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane extraction; halfword lane uses ofs[1] only, alignment is checked upstream.
    always_comb begin
        byte_sel = rdata[{ofs, 3'b000} +: 8];
        half_sel = ofs[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        case (load_op_e'(load_op))
            LoadOpLb:  data = {{24{byte_sel[7]}}, byte_sel};
            LoadOpLbu: data = {24'd0, byte_sel};
            LoadOpLh:  data = {{16{half_sel[15]}}, half_sel};
            LoadOpLhu: data = {16'd0, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: holds one instruction, waits for its data-SRAM response, aligns load data and
// hands {gr_we, dest, result, pc} to WB while publishing forwarding info to ID.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave ms_if
);

    logic                   ms_valid_q, ms_valid_d;
    logic                   buf_valid_q, buf_valid_d;
    logic [EsToMsBusWd-1:0] es_bus_q, es_bus_d;
    logic [31:0]            rdata_buf_q, rdata_buf_d;

    logic        mem_req;
    logic [2:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        ms_ready_go;
    logic        ms_allowin;
    logic        buf_capture;
    logic        fwd_valid;
    logic        fwd_blocked;
    logic [31:0] load_data;
    logic [31:0] align_data;
    logic [31:0] final_result;

    assign {mem_req, load_op, gr_we, dest, alu_result, pc} = es_bus_q;

    assign ms_ready_go = !mem_req || buf_valid_q || ms_if.data_sram_data_ok;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ms_if.ws_allowin);
    // Park the response only when it cannot be consumed this cycle.
    assign buf_capture = ms_if.data_sram_data_ok && ms_valid_q && mem_req && !buf_valid_q
                         && !ms_if.ws_allowin;
    assign load_data   = buf_valid_q ? rdata_buf_q : ms_if.data_sram_rdata;

    mem_load_align u_load_align (
        .load_op (load_op),
        .ofs     (alu_result[1:0]),
        .rdata   (load_data),
        .data    (align_data)
    );

    assign final_result = (load_op == LoadOpNone) ? alu_result : align_data;
    assign fwd_valid    = ms_valid_q && gr_we && (dest != 5'd0);
    assign fwd_blocked  = fwd_valid && (load_op != LoadOpNone) && !ms_ready_go;

    assign ms_if.ms_allowin     = ms_allowin;
    assign ms_if.ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_if.ms_to_ws_bus   = {gr_we, dest, final_result, pc};
    assign ms_if.ms_to_ds_bus   = {fwd_valid, fwd_blocked, dest, final_result};

    // Next-state: accept from EX when allowed, otherwise possibly buffer the SRAM response.
    always_comb begin
        ms_valid_d  = ms_valid_q;
        buf_valid_d = buf_valid_q;
        es_bus_d    = es_bus_q;
        rdata_buf_d = rdata_buf_q;
        if (ms_allowin) begin
            ms_valid_d  = ms_if.es_to_ms_valid;
            buf_valid_d = 1'b0;
            if (ms_if.es_to_ms_valid) begin
                es_bus_d = ms_if.es_to_ms_bus;
            end
        end else if (buf_capture) begin
            buf_valid_d = 1'b1;
            rdata_buf_d = ms_if.data_sram_rdata;
        end
    end

    // Stage registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            es_bus_q    <= '0;
            rdata_buf_q <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
            es_bus_q    <= es_bus_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        bit        mem_req;
        bit [2:0]  op;
        bit        gr_we;
        bit [4:0]  dest;
        bit [31:0] alu;
        bit [31:0] pc;
    } insn_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if ms_if ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .ms_if  (ms_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which instruction sits in MEM and whether its response was already seen.
    bit        occ;
    bit        resp;
    bit [31:0] saved;
    insn_t     cur;

    // Inputs applied in the current cycle, consumed by step().
    bit        in_v, in_wa, in_dok;
    insn_t     in_i;
    bit [31:0] in_rd;

    task automatic check_eq(input string tag, input logic [73:0] got, input logic [73:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [73:0] pack(input insn_t i);
        return {i.mem_req, i.op, i.gr_we, i.dest, i.alu, i.pc};
    endfunction

    // Architectural load result, computed arithmetically from the addressed lane.
    function automatic bit [31:0] ref_result(input bit [2:0] op, input bit [31:0] addr,
                                             input bit [31:0] word);
        bit [31:0] b, h;
        b = (word >> (8 * addr[1:0])) & 32'hFF;
        h = (word >> (16 * addr[1])) & 32'hFFFF;
        case (op)
            3'd0:    return addr;
            3'd1:    return (b ^ 32'h80) - 32'h80;
            3'd2:    return b;
            3'd3:    return (h ^ 32'h8000) - 32'h8000;
            3'd4:    return h;
            default: return word;
        endcase
    endfunction

    function automatic insn_t mk(input bit mr, input bit [2:0] op, input bit we,
                                 input bit [4:0] d, input bit [31:0] alu);
        insn_t i;
        i.mem_req = mr;
        i.op      = op;
        i.gr_we   = we;
        i.dest    = d;
        i.alu     = alu;
        i.pc      = $urandom;
        return i;
    endfunction

    function automatic insn_t rand_insn();
        insn_t i;
        i.mem_req = 1'($urandom_range(0, 1));
        i.op      = i.mem_req ? 3'($urandom_range(0, 7)) : 3'd0;
        i.gr_we   = (i.mem_req && i.op == 3'd0) ? 1'b0 : ($urandom_range(0, 7) != 0);
        i.dest    = 5'($urandom_range(0, 31));
        i.alu     = $urandom;
        i.pc      = $urandom;
        return i;
    endfunction

    task automatic drive_check(input bit v, input insn_t i, input bit wa, input bit dok,
                               input bit [31:0] rd);
        bit got_resp, done, fwd, blk;
        bit [31:0] res;
        @(negedge clk);
        in_v = v; in_i = i; in_wa = wa; in_dok = dok; in_rd = rd;
        ms_if.es_to_ms_valid    = v;
        ms_if.es_to_ms_bus      = pack(i);
        ms_if.ws_allowin        = wa;
        ms_if.data_sram_data_ok = dok;
        ms_if.data_sram_rdata   = rd;
        #2;
        got_resp = occ && cur.mem_req && !resp && dok;
        done     = occ && (!cur.mem_req || resp || got_resp);
        fwd      = occ && cur.gr_we && (cur.dest != 5'd0);
        blk      = fwd && (cur.op != 3'd0) && !done;
        res      = ref_result(cur.op, cur.alu, resp ? saved : rd);
        check_eq("allowin", 74'(ms_if.ms_allowin), 74'(!occ || (done && wa)));
        check_eq("ws_valid", 74'(ms_if.ms_to_ws_valid), 74'(done));
        check_eq("fwd_valid", 74'(ms_if.ms_to_ds_bus[38]), 74'(fwd));
        check_eq("fwd_blocked", 74'(ms_if.ms_to_ds_bus[37]), 74'(blk));
        if (done) begin
            check_eq("ws_bus", 74'(ms_if.ms_to_ws_bus), 74'({cur.gr_we, cur.dest, res, cur.pc}));
            if (fwd) begin
                check_eq("ds_data", 74'(ms_if.ms_to_ds_bus[36:0]), 74'({cur.dest, res}));
            end
        end
    endtask

    task automatic step();
        bit done, allow;
        @(posedge clk);
        done  = occ && (!cur.mem_req || resp || in_dok);
        allow = !occ || (done && in_wa);
        if (occ && cur.mem_req && !resp && in_dok && !in_wa) begin
            resp  = 1'b1;
            saved = in_rd;
        end
        if (allow) begin
            occ  = in_v;
            resp = 1'b0;
            if (in_v) cur = in_i;
        end
    endtask

    task automatic cycle(input bit v, input insn_t i, input bit wa, input bit dok,
                         input bit [31:0] rd);
        drive_check(v, i, wa, dok, rd);
        step();
    endtask

    insn_t idle_i, t_i;

    initial begin
        idle_i = mk(1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
        occ = 1'b0; resp = 1'b0; saved = '0; cur = idle_i;
        resetn = 1'b0;
        ms_if.es_to_ms_valid = 1'b0; ms_if.es_to_ms_bus = '0; ms_if.ws_allowin = 1'b0;
        ms_if.data_sram_data_ok = 1'b0; ms_if.data_sram_rdata = '0;
        #3;
        check_eq("rst_allowin", 74'(ms_if.ms_allowin), 74'(1'b1));
        check_eq("rst_ws_valid", 74'(ms_if.ms_to_ws_valid), 74'(1'b0));
        check_eq("rst_ws_bus", 74'(ms_if.ms_to_ws_bus), 74'(0));
        check_eq("rst_ds_bus", 74'(ms_if.ms_to_ds_bus), 74'(0));
        @(negedge clk);
        resetn = 1'b1;

        // ALU op passes straight through.
        t_i = mk(1'b0, 3'd0, 1'b1, 5'd5, 32'h1234);
        cycle(1'b1, t_i, 1'b1, 1'b0, $urandom);
        drive_check(1'b0, idle_i, 1'b1, 1'b0, $urandom);
        check_eq("t1_bus", 74'(ms_if.ms_to_ws_bus), 74'({1'b1, 5'd5, 32'h1234, t_i.pc}));
        step();

        // LB waiting two cycles, then sign-extended byte 3.
        t_i = mk(1'b1, 3'd1, 1'b1, 5'd7, 32'h0000_1003);
        cycle(1'b1, t_i, 1'b1, 1'b0, $urandom);
        for (int k = 0; k < 2; k++) begin
            drive_check(1'b0, idle_i, 1'b1, 1'b0, $urandom);
            check_eq("t2_blocked", 74'(ms_if.ms_to_ds_bus[37]), 74'(1'b1));
            step();
        end
        drive_check(1'b0, idle_i, 1'b1, 1'b1, 32'h80FF_0000);
        check_eq("t2_result", 74'(ms_if.ms_to_ws_bus[63:32]), 74'(32'hFFFF_FF80));
        step();

        // LHU response buffered while WB stalls.
        t_i = mk(1'b1, 3'd4, 1'b1, 5'd9, 32'h0000_2002);
        cycle(1'b1, t_i, 1'b1, 1'b0, $urandom);
        cycle(1'b0, idle_i, 1'b0, 1'b1, 32'hBEEF_1234);
        cycle(1'b0, idle_i, 1'b0, 1'b0, 32'h0);
        drive_check(1'b0, idle_i, 1'b1, 1'b0, 32'h0);
        check_eq("t3_result", 74'(ms_if.ms_to_ws_bus[63:32]), 74'(32'h0000_BEEF));
        step();
        cycle(1'b0, idle_i, 1'b1, 1'b0, 32'h0);

        // Back-to-back LW, one per cycle.
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, mk(1'b1, 3'd5, 1'b1, 5'(k + 1), 32'(k * 4)), 1'b1, k > 0, $urandom);
        end
        cycle(1'b0, idle_i, 1'b1, 1'b1, $urandom);

        // SW held until its response.
        t_i = mk(1'b1, 3'd0, 1'b0, 5'd3, 32'hCAFE_0010);
        cycle(1'b1, t_i, 1'b1, 1'b0, $urandom);
        cycle(1'b0, idle_i, 1'b1, 1'b0, $urandom);
        cycle(1'b0, idle_i, 1'b1, 1'b1, $urandom);

        // Asynchronous reset while a load waits.
        t_i = mk(1'b1, 3'd5, 1'b1, 5'd4, 32'h100);
        cycle(1'b1, t_i, 1'b1, 1'b0, $urandom);
        drive_check(1'b0, idle_i, 1'b1, 1'b0, $urandom);
        #1 resetn = 1'b0;
        #1;
        check_eq("t6_ws_valid", 74'(ms_if.ms_to_ws_valid), 74'(1'b0));
        check_eq("t6_allowin", 74'(ms_if.ms_allowin), 74'(1'b1));
        check_eq("t6_ds_bus", 74'(ms_if.ms_to_ds_bus), 74'(0));
        occ = 1'b0; resp = 1'b0; cur = idle_i;
        @(negedge clk);
        resetn = 1'b1;
        cycle(1'b0, idle_i, 1'b1, 1'b1, $urandom);
        cycle(1'b0, idle_i, 1'b1, 1'b0, $urandom);

        // Randomized traffic, including stray responses and WB back-pressure.
        for (int n = 0; n < 2000; n++) begin
            bit dok;
            if (occ && cur.mem_req && !resp) dok = ($urandom_range(0, 2) == 0);
            else dok = ($urandom_range(0, 15) == 0);
            cycle($urandom_range(0, 3) != 0, rand_insn(), $urandom_range(0, 3) != 0, dok,
                  $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
